// File: rtl/hazard_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use, branch operand and MUL/DIV hazards.
// Optional STALL_PERF_CNT_EN adds a saturating stall-cycle counter output StallCycles.
module hazard_stall_ctrl #(
   parameter int MD_LATENCY = 4,
   parameter int CNT_W      = 3
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic [4:0] ID_Rs,
   input  logic [4:0] ID_Rt,
   input  logic       ID_UsesRt,
   input  logic       ID_IsBranch,
   input  logic       ID_Taken,
   input  logic       ID_MulDiv,
   input  logic       ID_UsesHiLo,
   input  logic       EX_MemRead,
   input  logic       EX_RegWrite,
   input  logic [4:0] EX_WriteReg,
   input  logic       MEM_MemRead,
   input  logic [4:0] MEM_WriteReg,
   output logic       PCWrite,
   output logic       IF_ID_Write,
   output logic       IF_ID_Flush,
   output logic       ID_EX_Bubble,
   output logic       MulDivBusy
`ifdef STALL_PERF_CNT_EN
   ,
   output logic [31:0] StallCycles
`endif
);

   typedef enum logic {
      RUN,
      MD_BUSY
   } state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] md_cnt, md_cnt_nx;
   logic             ex_match, mem_match;
   logic             load_use, br_haz, md_haz, stall;

   // $zero is hard-wired, so writes to it never create a dependency
   function automatic logic src_match(input logic [4:0] r);
      return (r != 5'd0) &&
             ((r == ID_Rs) || (ID_UsesRt && (r == ID_Rt)));
   endfunction

   always_comb begin
      ex_match  = src_match(EX_WriteReg);
      mem_match = src_match(MEM_WriteReg);
      load_use  = EX_MemRead && ex_match;
      br_haz    = ID_IsBranch &&
                  ((EX_RegWrite && ex_match) ||
                   (MEM_MemRead && mem_match));
      md_haz    = (state == MD_BUSY) &&
                  (ID_MulDiv || ID_UsesHiLo);
      stall     = load_use || br_haz || md_haz;
   end

   always_comb begin
      PCWrite      = 1'b1;
      IF_ID_Write  = 1'b1;
      IF_ID_Flush  = 1'b0;
      ID_EX_Bubble = 1'b0;
      MulDivBusy   = (state == MD_BUSY);
      if (Rst) begin
         PCWrite      = 1'b0;
         IF_ID_Write  = 1'b0;
         IF_ID_Flush  = 1'b1;
         ID_EX_Bubble = 1'b1;
         MulDivBusy   = 1'b0;
      end else if (stall) begin
         PCWrite      = 1'b0;
         IF_ID_Write  = 1'b0;
         ID_EX_Bubble = 1'b1;
      end else begin
         IF_ID_Flush  = ID_Taken;
      end
   end

   always_comb begin
      state_nx  = state;
      md_cnt_nx = md_cnt;
      unique case (state)
         RUN: begin
            if (ID_MulDiv && !stall && (MD_LATENCY > 1)) begin
               state_nx  = MD_BUSY;
               md_cnt_nx = CNT_W'(MD_LATENCY - 1);
            end
         end
         MD_BUSY: begin
            md_cnt_nx = md_cnt - CNT_W'(1);
            if (md_cnt == CNT_W'(1)) begin
               state_nx  = RUN;
               md_cnt_nx = '0;
            end
         end
         default: begin
            state_nx  = RUN;
            md_cnt_nx = '0;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state  <= RUN;
         md_cnt <= '0;
      end else begin
         state  <= state_nx;
         md_cnt <= md_cnt_nx;
      end
   end

`ifdef STALL_PERF_CNT_EN
   always_ff @(posedge Clk) begin
      if (Rst)
         StallCycles <= '0;
      else if (stall && (StallCycles != 32'hFFFF_FFFF))
         StallCycles <= StallCycles + 32'd1;
   end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Randomized bench for hazard_stall_ctrl with a cycle-level reference model.
// Define STALL_PERF_CNT_EN to also check the StallCycles output.
module tb_hazard_stall_ctrl;

   localparam int LAT = 4;

   logic       Clk = 1'b0;
   logic       Rst;
   logic [4:0] ID_Rs, ID_Rt, EX_WriteReg, MEM_WriteReg;
   logic       ID_UsesRt, ID_IsBranch, ID_Taken, ID_MulDiv, ID_UsesHiLo;
   logic       EX_MemRead, EX_RegWrite, MEM_MemRead;
   logic       PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MulDivBusy;
`ifdef STALL_PERF_CNT_EN
   logic [31:0] StallCycles;
`endif

   hazard_stall_ctrl #(.MD_LATENCY(LAT), .CNT_W(3)) dut (
      .Clk(Clk), .Rst(Rst),
      .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
      .ID_IsBranch(ID_IsBranch), .ID_Taken(ID_Taken),
      .ID_MulDiv(ID_MulDiv), .ID_UsesHiLo(ID_UsesHiLo),
      .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite),
      .EX_WriteReg(EX_WriteReg), .MEM_MemRead(MEM_MemRead),
      .MEM_WriteReg(MEM_WriteReg),
      .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
      .IF_ID_Flush(IF_ID_Flush), .ID_EX_Bubble(ID_EX_Bubble),
      .MulDivBusy(MulDivBusy)
`ifdef STALL_PERF_CNT_EN
      , .StallCycles(StallCycles)
`endif
   );

   always #5 Clk = ~Clk;

   int          n_vec = 0;
   int          n_err = 0;
   int          busy_left = 0;
   longint      stall_total = 0;
   logic        m_stall;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   function automatic bit reads(input logic [4:0] r);
      return r != 0 && (r == ID_Rs || (ID_UsesRt && r == ID_Rt));
   endfunction

   task automatic idle();
      Rst = 0; ID_Rs = 0; ID_Rt = 0; ID_UsesRt = 0;
      ID_IsBranch = 0; ID_Taken = 0; ID_MulDiv = 0; ID_UsesHiLo = 0;
      EX_MemRead = 0; EX_RegWrite = 0; EX_WriteReg = 0;
      MEM_MemRead = 0; MEM_WriteReg = 0;
   endtask

   // Mid-cycle: compare all outputs against the model
   task automatic settle();
      bit lu, bh, mh;
      #4;
      lu = EX_MemRead && reads(EX_WriteReg);
      bh = ID_IsBranch && ((EX_RegWrite && reads(EX_WriteReg)) ||
                           (MEM_MemRead && reads(MEM_WriteReg)));
      mh = busy_left > 0 && (ID_MulDiv || ID_UsesHiLo);
      m_stall = lu || bh || mh;
      if (Rst) begin
         check("rst_pcw", {31'b0, PCWrite}, 0);
         check("rst_ifw", {31'b0, IF_ID_Write}, 0);
         check("rst_flush", {31'b0, IF_ID_Flush}, 1);
         check("rst_bub", {31'b0, ID_EX_Bubble}, 1);
         check("rst_busy", {31'b0, MulDivBusy}, 0);
      end else begin
         check("pcw", {31'b0, PCWrite}, {31'b0, !m_stall});
         check("ifw", {31'b0, IF_ID_Write}, {31'b0, !m_stall});
         check("flush", {31'b0, IF_ID_Flush},
               {31'b0, !m_stall && ID_Taken});
         check("bub", {31'b0, ID_EX_Bubble}, {31'b0, m_stall});
         check("busy", {31'b0, MulDivBusy}, {31'b0, busy_left > 0});
`ifdef STALL_PERF_CNT_EN
         check("perf", StallCycles, 32'(stall_total));
`endif
      end
   endtask

   // Advance the model across the clock edge, then step past it
   task automatic advance();
      if (Rst) begin
         busy_left = 0;
         stall_total = 0;
      end else begin
         if (m_stall && stall_total < 64'hFFFF_FFFF) stall_total++;
         if (busy_left > 0) busy_left--;
         else if (ID_MulDiv && !m_stall && LAT > 1) busy_left = LAT - 1;
      end
      @(posedge Clk);
      #1;
   endtask

   initial begin
      idle();
      Rst = 1;
      settle(); advance();
      settle(); advance();
      Rst = 0;

      // load-use: lw $8 in EX, add $9,$8,$10 in ID
      EX_MemRead = 1; EX_WriteReg = 8;
      ID_Rs = 8; ID_Rt = 10; ID_UsesRt = 1;
      settle();
      check("lu_pcw", {31'b0, PCWrite}, 0);
      check("lu_bub", {31'b0, ID_EX_Bubble}, 1);
      advance();
      idle(); MEM_MemRead = 1; MEM_WriteReg = 8;
      ID_Rs = 8; ID_Rt = 10; ID_UsesRt = 1;
      settle();
      check("lu_go", {30'b0, PCWrite, IF_ID_Write}, 3);
      advance();

      // MUL/DIV then mfhi stalled for the busy window
      idle(); ID_MulDiv = 1;
      settle();
      check("md_iss_busy", {31'b0, MulDivBusy}, 0);
      advance();
      idle(); ID_UsesHiLo = 1;
      for (int c = 1; c <= 3; c++) begin
         settle();
         check("md_hilo_stall", {31'b0, PCWrite}, 0);
         check("md_busy_on", {31'b0, MulDivBusy}, 1);
         advance();
      end
      settle();
      check("md_hilo_go", {31'b0, PCWrite}, 1);
      check("md_busy_off", {31'b0, MulDivBusy}, 0);
`ifdef STALL_PERF_CNT_EN
      check("perf_four", StallCycles, 4);
`endif
      advance();

      // $zero and unused rt never hazard
      idle(); EX_MemRead = 1; EX_WriteReg = 0;
      settle();
      check("zero_nostall", {31'b0, PCWrite}, 1);
      advance();
      idle(); EX_MemRead = 1; EX_WriteReg = 7; ID_Rt = 7; ID_Rs = 3;
      settle();
      check("rt_unused", {31'b0, ID_EX_Bubble}, 0);
      advance();

      // beq $4,$5 behind add $5, then taken
      idle(); ID_IsBranch = 1; ID_Rs = 4; ID_Rt = 5; ID_UsesRt = 1;
      ID_Taken = 1; EX_RegWrite = 1; EX_WriteReg = 5;
      settle();
      check("br_stall", {31'b0, ID_EX_Bubble}, 1);
      check("br_noflush", {31'b0, IF_ID_Flush}, 0);
      advance();
      idle(); ID_IsBranch = 1; ID_Rs = 4; ID_Rt = 5; ID_UsesRt = 1;
      ID_Taken = 1;
      settle();
      check("br_flush", {31'b0, IF_ID_Flush}, 1);
      advance();
      idle();
      settle();
      check("br_flush_once", {31'b0, IF_ID_Flush}, 0);
      advance();

      // reset abandons a MUL/DIV in flight
      ID_MulDiv = 1;
      settle(); advance();
      idle();
      settle(); advance();
      Rst = 1;
      settle();
      check("rmd_flush", {31'b0, IF_ID_Flush}, 1);
      check("rmd_pcw", {31'b0, PCWrite}, 0);
      advance();
      Rst = 0;
      settle();
      check("rmd_run", {31'b0, MulDivBusy}, 0);
      advance();

      for (int i = 0; i < 3000; i++) begin
         Rst = ($urandom_range(0, 40) == 0);
         ID_Rs = 5'($urandom_range(0, 3));
         ID_Rt = 5'($urandom_range(0, 3));
         ID_UsesRt = 1'($urandom);
         ID_IsBranch = ($urandom_range(0, 3) == 0);
         ID_Taken = ($urandom_range(0, 4) == 0);
         ID_MulDiv = ($urandom_range(0, 5) == 0);
         ID_UsesHiLo = ($urandom_range(0, 5) == 0);
         EX_MemRead = ($urandom_range(0, 3) == 0);
         EX_RegWrite = 1'($urandom);
         EX_WriteReg = 5'($urandom_range(0, 3));
         MEM_MemRead = ($urandom_range(0, 3) == 0);
         MEM_WriteReg = 5'($urandom_range(0, 3));
         settle(); advance();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
